// File: rtl/iso7816_pkg.sv
// Shared ISO7816 definitions: character FSM encoding and line conventions.
// Used by both the transmit and receive cores.
package iso7816_pkg;

    localparam int   CLOCK_PER_BIT_WIDTH = 13;
    localparam logic START_BIT           = 1'b0;
    localparam logic STOP_BIT1           = 1'b1;
    localparam logic STOP_BIT2           = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        NAKWAIT
    } txState_t;

endpackage

// File: rtl/iso7816_etu_counter.sv
// ETU timer: counts 0..limit and wraps, with a pulse at the 3/4 point
// used to sample the guard time for a T=0 error signal.
module iso7816_etu_counter #(
    parameter int WIDTH = iso7816_pkg::CLOCK_PER_BIT_WIDTH
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             wrap,
    output logic             threeQuarter
);

    logic [WIDTH-1:0] count;
    logic [WIDTH+1:0] etuLen;
    logic [WIDTH+1:0] quarterPoint;

    // Two extra bits keep (limit+1)*3 from overflowing.
    assign etuLen       = {2'b00, limit} + (WIDTH+2)'(1);
    assign quarterPoint = ((etuLen << 1) + etuLen) >> 2;

    assign wrap         = enable && (count == limit);
    assign threeQuarter = enable && ({2'b00, count} == quarterPoint);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/iso7816_tx_core.sv
// ISO7816-3 character transmitter: start, 8 data bits LSB first, parity,
// 1 or 2 guard ETUs, with optional T=0 NAK detection and retransmission.
module iso7816_tx_core #(
    parameter int   CLOCK_PER_BIT_WIDTH = iso7816_pkg::CLOCK_PER_BIT_WIDTH,
    parameter logic OUT_POLARITY        = 1'b0,
    parameter logic PARITY_POLARITY     = 1'b0,
    parameter logic START_BIT           = iso7816_pkg::START_BIT,
    parameter logic STOP_BIT1           = iso7816_pkg::STOP_BIT1,
    parameter logic STOP_BIT2           = iso7816_pkg::STOP_BIT2,
    parameter int   MAX_RETRIES         = 3
) (
    input  logic                           clk,
    input  logic                           nReset,
    input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
    input  logic                           stopBit2,
    input  logic                           errorCheck,
    input  logic [7:0]                     dataIn,
    input  logic                           loadDataIn,
    input  logic                           ackFlags,
    input  logic                           serialIn,
    output logic                           serialOut,
    output logic                           full,
    output logic                           run,
    output logic                           endOfTx,
    output logic                           errorFlag
);

    import iso7816_pkg::*;

    txState_t state, nextState;

    logic [7:0]                     holdReg;
    logic [7:0]                     shiftReg;
    logic [CLOCK_PER_BIT_WIDTH-1:0] cpbReg;
    logic                           stop2Reg;
    logic [2:0]                     bitIdx;
    logic [2:0]                     retryCnt;
    logic                           dropByte;
    logic                           waitHigh;

    logic transfer, loadAccept, advanceBit, clearEtu;
    logic frameDone, nakHit, retry, dropDone, lineLevel;
    logic etuWrap, etuQuarter, lineHigh, lastTry;

    assign run        = (state != IDLE);
    assign lineHigh   = serialIn ^ OUT_POLARITY;
    assign lastTry    = (retryCnt == 3'(MAX_RETRIES));
    assign loadAccept = loadDataIn && (!full || transfer);

    iso7816_etu_counter #(
        .WIDTH(CLOCK_PER_BIT_WIDTH)
    ) etuCounter (
        .clk         (clk),
        .nReset      (nReset),
        .enable      (state != IDLE),
        .clear       (clearEtu),
        .limit       (cpbReg),
        .wrap        (etuWrap),
        .threeQuarter(etuQuarter)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        transfer   = 1'b0;
        advanceBit = 1'b0;
        clearEtu   = 1'b0;
        frameDone  = 1'b0;
        nakHit     = 1'b0;
        retry      = 1'b0;
        dropDone   = 1'b0;
        lineLevel  = STOP_BIT1;
        unique case (state)
            IDLE: begin
                if (full && !errorFlag) begin
                    nextState = START;
                    transfer  = 1'b1;
                    clearEtu  = 1'b1;
                end
            end
            START: begin
                lineLevel = START_BIT;
                if (etuWrap) nextState = DATA;
            end
            DATA: begin
                lineLevel  = shiftReg[bitIdx];
                advanceBit = etuWrap;
                if (etuWrap && bitIdx == 3'd7) nextState = PARITY;
            end
            PARITY: begin
                lineLevel = ^shiftReg ^ PARITY_POLARITY;
                if (etuWrap) nextState = STOP1;
            end
            STOP1: begin
                if (errorCheck && etuQuarter && !lineHigh) begin
                    nakHit    = 1'b1;
                    clearEtu  = 1'b1;
                    nextState = NAKWAIT;
                end else if (etuWrap) begin
                    if (stop2Reg) begin
                        nextState = STOP2;
                    end else begin
                        nextState = IDLE;
                        frameDone = 1'b1;
                    end
                end
            end
            STOP2: begin
                lineLevel = STOP_BIT2;
                if (etuWrap) begin
                    nextState = IDLE;
                    frameDone = 1'b1;
                end
            end
            NAKWAIT: begin
                // Hold the timer until the card releases the line, then 2 ETUs.
                if (waitHigh) begin
                    clearEtu = 1'b1;
                end else if (etuWrap && bitIdx[0]) begin
                    dropDone  = dropByte;
                    retry     = !dropByte;
                    nextState = dropByte ? IDLE : START;
                end else begin
                    advanceBit = etuWrap;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            holdReg   <= '0;
            shiftReg  <= '0;
            cpbReg    <= '0;
            stop2Reg  <= 1'b0;
            full      <= 1'b0;
            bitIdx    <= '0;
            retryCnt  <= '0;
            dropByte  <= 1'b0;
            waitHigh  <= 1'b0;
            errorFlag <= 1'b0;
            endOfTx   <= 1'b0;
            serialOut <= STOP_BIT1 ^ OUT_POLARITY;
        end else begin
            serialOut <= lineLevel ^ OUT_POLARITY;
            endOfTx   <= frameDone;
            if (loadAccept) begin
                holdReg <= dataIn;
                full    <= 1'b1;
            end else if (transfer) begin
                full <= 1'b0;
            end
            if (transfer) begin
                shiftReg <= holdReg;
                cpbReg   <= clocksPerBit;
                stop2Reg <= stopBit2;
            end
            if (transfer || nakHit || retry) begin
                bitIdx <= '0;
            end else if (advanceBit) begin
                bitIdx <= bitIdx + 3'd1;
            end
            if (frameDone || dropDone) begin
                retryCnt <= '0;
            end else if (retry) begin
                retryCnt <= retryCnt + 3'd1;
            end
            if (nakHit) begin
                waitHigh <= 1'b1;
                dropByte <= lastTry;
            end else begin
                if (waitHigh && lineHigh) waitHigh <= 1'b0;
                if (dropDone) dropByte <= 1'b0;
            end
            if (nakHit && lastTry) begin
                errorFlag <= 1'b1;
            end else if (ackFlags) begin
                errorFlag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iso7816_tx_core.sv
// Bench for iso7816_tx_core: a line monitor captures frames (and plays the
// card's NAK) into a queue that each test compares with its expectations.
module tb_iso7816_tx_core;

    logic        clk = 1'b0;
    logic        nReset;
    logic [12:0] cpb;
    logic        stopBit2;
    logic        errorCheck;
    logic [7:0]  dataIn;
    logic        loadDataIn;
    logic        ackFlags;
    logic        serialIn;
    logic        serialOut;
    logic        full;
    logic        run;
    logic        endOfTx;
    logic        errorFlag;

    logic        nakPull;
    int          etu = 4;
    int          nakLeft = 0;
    int          eotCount = 0;
    int          vectors = 0;
    int          miscompares = 0;

    logic [10:0] expQ[$];
    logic [10:0] capQ[$];
    bit          nakQ[$];

    always #5 clk = ~clk;

    // Open-drain line: the card can only pull it low.
    assign serialIn = serialOut & ~nakPull;

    iso7816_tx_core dut (
        .clk         (clk),
        .nReset      (nReset),
        .clocksPerBit(cpb),
        .stopBit2    (stopBit2),
        .errorCheck  (errorCheck),
        .dataIn      (dataIn),
        .loadDataIn  (loadDataIn),
        .ackFlags    (ackFlags),
        .serialIn    (serialIn),
        .serialOut   (serialOut),
        .full        (full),
        .run         (run),
        .endOfTx     (endOfTx),
        .errorFlag   (errorFlag)
    );

    always @(posedge clk) begin
        if (endOfTx) eotCount <= eotCount + 1;
    end

    function automatic logic [10:0] frameOf(input logic [7:0] b);
        return {1'b1, ^b, b, 1'b0};
    endfunction

    initial begin : monitor
        logic        prevLine;
        logic        doNak;
        logic [10:0] bits;
        int          len;
        prevLine = 1'b1;
        nakPull  = 1'b0;
        forever begin
            @(negedge clk);
            if (prevLine && !serialOut && nReset) begin
                doNak = (nakLeft > 0);
                len   = doNak ? 12 * etu : 11 * etu;
                bits  = '0;
                for (int c = 0; c < len; c++) begin
                    if (c % etu == etu / 2 && c < 11 * etu)
                        bits[c / etu] = serialOut;
                    nakPull = doNak && (2 * c >= 21 * etu);
                    if (c + 1 < len) @(negedge clk);
                end
                nakPull = 1'b0;
                if (doNak) nakLeft--;
                capQ.push_back(bits);
                nakQ.push_back(doNak);
                prevLine = 1'b1;
            end else begin
                prevLine = serialOut;
            end
        end
    end

    task automatic loadByte(input logic [7:0] b);
        dataIn     = b;
        loadDataIn = 1'b1;
        @(negedge clk);
        loadDataIn = 1'b0;
    endtask

    task automatic waitIdle();
        int t = 0;
        while (run && t < 3000) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (run !== 1'b0) begin
            miscompares++;
            $display("FAIL idle timeout: run=%b want 0", run);
        end
    endtask

    task automatic waitFrames(input int n, output bit ok);
        int t = 0;
        while (capQ.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ok = (capQ.size() >= n);
    endtask

    task automatic test_reset();
        vectors++;
        if (serialOut !== 1'b1) begin
            miscompares++;
            $display("FAIL reset serialOut: got %b want 1", serialOut);
        end
        vectors++;
        if (full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset full: got %b want 0", full);
        end
        vectors++;
        if (run !== 1'b0) begin
            miscompares++;
            $display("FAIL reset run: got %b want 0", run);
        end
        vectors++;
        if (endOfTx !== 1'b0) begin
            miscompares++;
            $display("FAIL reset endOfTx: got %b want 0", endOfTx);
        end
        vectors++;
        if (errorFlag !== 1'b0) begin
            miscompares++;
            $display("FAIL reset errorFlag: got %b want 0", errorFlag);
        end
    endtask

    task automatic test_single_frame();
        int cycles;
        bit ok;
        logic [10:0] e, c;
        cpb = 13'd3;
        etu = 4;
        expQ.push_back(frameOf(8'h3B));
        loadByte(8'h3B);
        vectors++;
        if (full !== 1'b1 || run !== 1'b0) begin
            miscompares++;
            $display("FAIL single load: full=%b run=%b want 1 0", full, run);
        end
        @(negedge clk);
        vectors++;
        if (run !== 1'b1 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL single xfer: run=%b full=%b want 1 0", run, full);
        end
        @(negedge clk);
        vectors++;
        if (serialOut !== 1'b0) begin
            miscompares++;
            $display("FAIL single start latency: got %b want 0", serialOut);
        end
        cycles = 2;
        while (!endOfTx && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        vectors++;
        if (cycles - 1 != 44) begin
            miscompares++;
            $display("FAIL single eot time: got %0d want 44", cycles - 1);
        end
        vectors++;
        if (run !== 1'b0) begin
            miscompares++;
            $display("FAIL single run at eot: got %b want 0", run);
        end
        @(negedge clk);
        vectors++;
        if (endOfTx !== 1'b0) begin
            miscompares++;
            $display("FAIL single eot width: got %b want 0", endOfTx);
        end
        waitFrames(1, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single frame timeout: got %0d want 1", capQ.size());
        end
        while (expQ.size() > 0 && capQ.size() > 0) begin
            e = expQ.pop_front();
            c = capQ.pop_front();
            void'(nakQ.pop_front());
            vectors++;
            if (c !== e) begin
                miscompares++;
                $display("FAIL single frame: got %b want %b", c, e);
            end
        end
        expQ.delete();
    endtask

    task automatic test_back_to_back();
        int t;
        bit ok;
        logic [10:0] e, c;
        expQ.push_back(frameOf(8'h3B));
        expQ.push_back(frameOf(8'h00));
        loadByte(8'h3B);
        t = 0;
        while (!run && t < 50) begin
            @(negedge clk);
            t++;
        end
        loadByte(8'h00);
        vectors++;
        if (full !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b full: got %b want 1", full);
        end
        t = 0;
        while (!endOfTx && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        vectors++;
        if (run !== 1'b1 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b restart: run=%b full=%b want 1 0", run, full);
        end
        waitFrames(2, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b frame timeout: got %0d want 2", capQ.size());
        end
        while (expQ.size() > 0 && capQ.size() > 0) begin
            e = expQ.pop_front();
            c = capQ.pop_front();
            void'(nakQ.pop_front());
            vectors++;
            if (c !== e) begin
                miscompares++;
                $display("FAIL b2b frame: got %b want %b", c, e);
            end
        end
        expQ.delete();
        waitIdle();
    endtask

    task automatic test_nak_retransmit();
        int eot0;
        bit ok;
        bit n;
        bit expNak[2] = '{1'b1, 1'b0};
        logic [10:0] e, c;
        cpb        = 13'd7;
        etu        = 8;
        errorCheck = 1'b1;
        nakLeft    = 1;
        eot0       = eotCount;
        expQ.push_back(frameOf(8'h96));
        expQ.push_back(frameOf(8'h96));
        loadByte(8'h96);
        waitFrames(1, ok);
        vectors++;
        if (eotCount != eot0 || run !== 1'b1) begin
            miscompares++;
            $display("FAIL nak wait: eot=%0d run=%b want 0 1", eotCount - eot0, run);
        end
        waitFrames(2, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL nak frame timeout: got %0d want 2", capQ.size());
        end
        waitIdle();
        @(negedge clk);
        vectors++;
        if (eotCount - eot0 != 1) begin
            miscompares++;
            $display("FAIL nak eot count: got %0d want 1", eotCount - eot0);
        end
        for (int i = 0; i < 2 && capQ.size() > 0; i++) begin
            e = expQ.pop_front();
            c = capQ.pop_front();
            n = nakQ.pop_front();
            vectors++;
            if (c !== e || n !== expNak[i]) begin
                miscompares++;
                $display("FAIL nak frame %0d: got %b/%b want %b/%b", i, c, n, e, expNak[i]);
            end
        end
        expQ.delete();
    endtask

    task automatic test_retry_limit();
        int eot0;
        int t;
        bit ok;
        bit n;
        logic [10:0] e, c;
        cpb        = 13'd7;
        etu        = 8;
        errorCheck = 1'b1;
        nakLeft    = 4;
        eot0       = eotCount;
        for (int i = 0; i < 4; i++) expQ.push_back(frameOf(8'hC3));
        expQ.push_back(frameOf(8'h5A));
        loadByte(8'hC3);
        t = 0;
        while (!run && t < 50) begin
            @(negedge clk);
            t++;
        end
        loadByte(8'h5A);
        waitFrames(4, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL retry frame timeout: got %0d want 4", capQ.size());
        end
        vectors++;
        if (errorFlag !== 1'b1 || full !== 1'b1) begin
            miscompares++;
            $display("FAIL retry flag: err=%b full=%b want 1 1", errorFlag, full);
        end
        waitIdle();
        repeat (4 * etu) @(negedge clk);
        vectors++;
        if (run !== 1'b0 || capQ.size() != 4 || eotCount != eot0) begin
            miscompares++;
            $display("FAIL retry hold: run=%b frames=%0d eot=%0d want 0 4 0",
                     run, capQ.size(), eotCount - eot0);
        end
        ackFlags = 1'b1;
        @(negedge clk);
        ackFlags = 1'b0;
        vectors++;
        if (errorFlag !== 1'b0) begin
            miscompares++;
            $display("FAIL retry ack: got %b want 0", errorFlag);
        end
        waitFrames(5, ok);
        waitIdle();
        @(negedge clk);
        vectors++;
        if (eotCount - eot0 != 1) begin
            miscompares++;
            $display("FAIL retry eot count: got %0d want 1", eotCount - eot0);
        end
        for (int i = 0; i < 5 && capQ.size() > 0; i++) begin
            e = expQ.pop_front();
            c = capQ.pop_front();
            n = nakQ.pop_front();
            vectors++;
            if (c !== e || n !== (i < 4)) begin
                miscompares++;
                $display("FAIL retry frame %0d: got %b/%b want %b/%b", i, c, n, e, i < 4);
            end
        end
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL retry missing frames: got %0d want 0", expQ.size());
        end
        expQ.delete();
        errorCheck = 1'b0;
        nakLeft    = 0;
    endtask

    task automatic test_load_while_full();
        int t;
        bit ok;
        logic [10:0] e, c;
        cpb = 13'd3;
        etu = 4;
        expQ.push_back(frameOf(8'h11));
        expQ.push_back(frameOf(8'hA5));
        loadByte(8'h11);
        t = 0;
        while (!run && t < 50) begin
            @(negedge clk);
            t++;
        end
        loadByte(8'hA5);
        loadByte(8'h5A);
        vectors++;
        if (full !== 1'b1) begin
            miscompares++;
            $display("FAIL drop full: got %b want 1", full);
        end
        waitFrames(2, ok);
        waitIdle();
        repeat (3 * etu) @(negedge clk);
        vectors++;
        if (run !== 1'b0 || full !== 1'b0 || capQ.size() != 2) begin
            miscompares++;
            $display("FAIL drop extra: run=%b full=%b frames=%0d want 0 0 2",
                     run, full, capQ.size());
        end
        while (expQ.size() > 0 && capQ.size() > 0) begin
            e = expQ.pop_front();
            c = capQ.pop_front();
            void'(nakQ.pop_front());
            vectors++;
            if (c !== e) begin
                miscompares++;
                $display("FAIL drop frame: got %b want %b", c, e);
            end
        end
        expQ.delete();
        capQ.delete();
        nakQ.delete();
    endtask

    task automatic test_reset_midframe();
        int t;
        bit ok;
        logic [10:0] e, c;
        cpb = 13'd3;
        etu = 4;
        loadByte(8'h0F);
        t = 0;
        while (!run && t < 50) begin
            @(negedge clk);
            t++;
        end
        loadByte(8'h77);
        repeat (16) @(negedge clk);
        nReset = 1'b0;
        #1;
        vectors++;
        if (serialOut !== 1'b1 || run !== 1'b0 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset: line=%b run=%b full=%b want 1 0 0",
                     serialOut, run, full);
        end
        repeat (12 * etu) @(negedge clk);
        nReset = 1'b1;
        capQ.delete();
        nakQ.delete();
        repeat (8 * etu) @(negedge clk);
        vectors++;
        if (run !== 1'b0 || capQ.size() != 0) begin
            miscompares++;
            $display("FAIL midreset lost byte: run=%b frames=%0d want 0 0",
                     run, capQ.size());
        end
        expQ.push_back(frameOf(8'h42));
        loadByte(8'h42);
        waitFrames(1, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL midreset frame timeout: got %0d want 1", capQ.size());
        end
        while (expQ.size() > 0 && capQ.size() > 0) begin
            e = expQ.pop_front();
            c = capQ.pop_front();
            void'(nakQ.pop_front());
            vectors++;
            if (c !== e) begin
                miscompares++;
                $display("FAIL midreset frame: got %b want %b", c, e);
            end
        end
        waitIdle();
    endtask

    initial begin
        nReset     = 1'b0;
        cpb        = 13'd3;
        stopBit2   = 1'b0;
        errorCheck = 1'b0;
        dataIn     = 8'h00;
        loadDataIn = 1'b0;
        ackFlags   = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        nReset = 1'b1;
        repeat (2) @(negedge clk);
        test_single_frame();
        repeat (4) @(negedge clk);
        test_back_to_back();
        repeat (4) @(negedge clk);
        test_nak_retransmit();
        repeat (4) @(negedge clk);
        test_retry_limit();
        repeat (4) @(negedge clk);
        test_load_while_full();
        repeat (4) @(negedge clk);
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
